// File: rtl/muldiv_seq.sv
// Sequential signed 32x32 multiply / divide unit with HI/LO registers and pipeline interlock.
// One shift-add or restoring-divide step per cycle; results commit to HI/LO in a single edge.
module muldiv_seq #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start_i,
    input  logic        Div_i,
    input  logic [31:0] A_i,
    input  logic [31:0] B_i,
    input  logic        MfHi_i,
    input  logic        MfLo_i,
    output logic [31:0] HI_o,
    output logic [31:0] LO_o,
    output logic        Busy_o,
    output logic        Stall_o,
    output logic        Done_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q;
    logic [63:0] acc_q;
    logic [31:0] opb_q;
    logic [4:0]  cnt_q;
    logic        div_q, neg_lo_q, neg_hi_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] acc_neg;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        // Negating 32'h8000_0000 yields itself, which reads as unsigned 2^31.
        abs_a    = A_i[31] ? -A_i : A_i;
        abs_b    = B_i[31] ? -B_i : B_i;
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
        // Remainder is compared as 33 bits so a divisor near 2^32 cannot overflow it.
        div_diff = {1'b0, acc_q[63:31]} - {2'b00, opb_q};
        div_next = div_diff[33] ? {acc_q[62:0], 1'b0}
                                : {div_diff[31:0], acc_q[30:0], 1'b1};
        acc_neg  = -acc_q;
        if (div_q) begin
            res_lo = neg_lo_q ? -acc_q[31:0] : acc_q[31:0];
            res_hi = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
        end else begin
            {res_hi, res_lo} = neg_lo_q ? acc_neg : acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Start_i) begin
                        if (Div_i && (B_i == 32'h0)) begin
                            hi_q   <= A_i;
                            lo_q   <= DIV0_LO;
                            done_q <= 1'b1;
                        end else begin
                            div_q    <= Div_i;
                            opb_q    <= Div_i ? abs_b : abs_a;
                            acc_q    <= {32'h0, (Div_i ? abs_a : abs_b)};
                            neg_lo_q <= A_i[31] ^ B_i[31];
                            neg_hi_q <= Div_i ? A_i[31] : (A_i[31] ^ B_i[31]);
                            cnt_q    <= '0;
                            state_q  <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign HI_o    = hi_q;
    assign LO_o    = lo_q;
    assign Done_o  = done_q;
    assign Busy_o  = (state_q != StIdle);
    assign Stall_o = Busy_o & (Start_i | MfHi_i | MfLo_i);

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against a plain-arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start_i = 1'b0, Div_i = 1'b0, MfHi_i = 1'b0, MfLo_i = 1'b0;
    logic [31:0] A_i = '0, B_i = '0;
    logic [31:0] HI_o, LO_o;
    logic        Busy_o, Stall_o, Done_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] model_hi = '0, model_lo = '0;

    muldiv_seq #(.DIV0_LO(32'hFFFF_FFFF)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start_i(Start_i),
        .Div_i  (Div_i),
        .A_i    (A_i),
        .B_i    (B_i),
        .MfHi_i (MfHi_i),
        .MfLo_i (MfLo_i),
        .HI_o   (HI_o),
        .LO_o   (LO_o),
        .Busy_o (Busy_o),
        .Stall_o(Stall_o),
        .Done_o (Done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic void ref_op(input logic dv, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!dv) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'h0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else begin
            p  = sa / sb;
            lo = p[31:0];
            p  = sa % sb;
            hi = p[31:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at the sample point just after the accepting edge of a non-div0 operation.
    task automatic finish_op(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                             input bit scramble);
        int busy_cycles = 0;
        int hold_bad = 0;
        while (Busy_o && busy_cycles < 40) begin
            busy_cycles++;
            if (HI_o !== model_hi || LO_o !== model_lo) hold_bad++;
            if (Done_o) hold_bad++;
            if (scramble) begin
                A_i   = $urandom;
                B_i   = $urandom;
                Div_i = 1'($urandom);
            end
            tick();
        end
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'd33);
        check({tag, " hold"}, 64'(hold_bad), 64'd0);
        check({tag, " done"}, 64'(Done_o), 64'd1);
        check({tag, " hilo"}, {HI_o, LO_o}, {ehi, elo});
        model_hi = ehi;
        model_lo = elo;
        tick();
        check({tag, " done_pulse"}, 64'(Done_o), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic dv, input logic [31:0] a,
                         input logic [31:0] b, input bit scramble);
        logic [31:0] ehi, elo;
        ref_op(dv, a, b, ehi, elo);
        Start_i = 1'b1;
        Div_i   = dv;
        A_i     = a;
        B_i     = b;
        tick();
        Start_i = 1'b0;
        if (dv && b == 32'h0) begin
            check({tag, " div0_busy"}, 64'(Busy_o), 64'd0);
            check({tag, " div0_done"}, 64'(Done_o), 64'd1);
            check({tag, " div0_hilo"}, {HI_o, LO_o}, {ehi, elo});
            model_hi = ehi;
            model_lo = elo;
            tick();
            check({tag, " div0_idle"}, {63'd0, Busy_o | Done_o}, 64'd0);
        end else begin
            finish_op(tag, ehi, elo, scramble);
        end
    endtask

    initial begin
        logic [31:0] a1, b1, a2, b2, ehi, elo;
        int bad;

        #2;
        check("reset_state", {HI_o, LO_o}, 64'd0);
        check("reset_flags", {61'd0, Busy_o, Done_o, Stall_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Accepted on the very first edge after reset release.
        do_op("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check("mult_7_m3 const", {HI_o, LO_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_m7_2 const", {HI_o, LO_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_min_m1 const", {HI_o, LO_o}, 64'h0000_0000_8000_0000);
        do_op("div_5_0", 1'b1, 32'd5, 32'd0, 1'b0);
        check("div_5_0 const", {HI_o, LO_o}, 64'h0000_0005_FFFF_FFFF);
        do_op("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("div_big", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a1 = $urandom;
            b1 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) b1 = 32'($urandom_range(0, 9)) - 32'd5;
            do_op($sformatf("rand%0d", i), 1'($urandom), a1, b1, i[0]);
        end

        // Interlock: second Start at N+5, mflo at N+10, both held until accepted.
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        ref_op(1'b0, a1, b1, ehi, elo);
        Start_i = 1'b1; Div_i = 1'b0; A_i = a1; B_i = b1;
        tick();
        Start_i = 1'b0;
        bad = 0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 5) begin
                Start_i = 1'b1; Div_i = 1'b0; A_i = a2; B_i = b2;
            end
            if (k == 10) MfLo_i = 1'b1;
            #1;
            if (k == 4) check("ilk stall_before", 64'(Stall_o), 64'd0);
            if (k == 5) check("ilk stall_start", 64'(Stall_o), 64'd1);
            if (k == 32) check("ilk stall_last", 64'(Stall_o), 64'd1);
            if (k > 5 && k < 32 && !Stall_o) bad++;
            if (k == 33) begin
                check("ilk stall_idle", 64'(Stall_o), 64'd0);
                check("ilk first_result", {HI_o, LO_o}, {ehi, elo});
                check("ilk first_done", 64'(Done_o), 64'd1);
            end
        end
        check("ilk stall_run", 64'(bad), 64'd0);
        model_hi = ehi;
        model_lo = elo;
        tick();
        Start_i = 1'b0;
        MfLo_i  = 1'b0;
        check("ilk second_accept", 64'(Busy_o), 64'd1);
        ref_op(1'b0, a2, b2, ehi, elo);
        finish_op("ilk second", ehi, elo, 1'b0);

        // Reset in the middle of a calculation.
        Start_i = 1'b1; Div_i = 1'b1; A_i = $urandom; B_i = 32'd3;
        tick();
        Start_i = 1'b0;
        repeat (15) tick();
        check("rst busy_before", 64'(Busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst hilo", {HI_o, LO_o}, 64'd0);
        check("rst flags", {62'd0, Busy_o, Done_o}, 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (Done_o || Busy_o || HI_o !== 32'h0 || LO_o !== 32'h0) bad++;
        end
        check("rst no_commit", 64'(bad), 64'd0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 1'b0, $urandom, $urandom, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
